// File: rtl/dm_pkg.sv
// Shared encodings, MMIO offsets and payload types for the data-memory stage.
package dm_pkg;

   typedef enum logic [1:0] {
      MOP_WORD = 2'b00,
      MOP_HALF = 2'b01,
      MOP_BYTE = 2'b10,
      MOP_RSVD = 2'b11
   } mem_op_e;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned LANES      = 4;
   localparam int unsigned LED_W      = 16;
   localparam int unsigned MMIO_OFF_W = 4;

   localparam logic [MMIO_OFF_W-1:0] OFF_LED    = 4'h0;
   localparam logic [MMIO_OFF_W-1:0] OFF_CYCLE  = 4'h4;
   localparam logic [MMIO_OFF_W-1:0] OFF_STATUS = 4'h8;
   localparam logic [MMIO_OFF_W-1:0] OFF_FADDR  = 4'hC;

   localparam int unsigned STATUS_FAULT_BIT = 0;

   // Store payload handed from the lane logic to the RAM write port.
   typedef struct packed {
      logic [LANES-1:0]  be;
      logic [DATA_W-1:0] data;
   } store_t;

endpackage

// File: rtl/dm_lane.sv
// Byte-lane logic: store enables/replication, load extract/extend, alignment check.
module dm_lane
   import dm_pkg::*;
(
   input  logic [1:0]        addr_lo,
   input  logic [1:0]        mem_op,
   input  logic              load_unsigned,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rword,
   output store_t            store_c,
   output logic [DATA_W-1:0] load_c,
   output logic              misalign_c
);

   mem_op_e     op;
   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   assign op = mem_op_e'(mem_op);

   always_comb begin
      store_c    = '0;
      load_c     = '0;
      misalign_c = 1'b0;
      half_sel   = addr_lo[1] ? rword[31:16] : rword[15:0];
      byte_sel   = rword[{addr_lo, 3'b000} +: 8];
      case (op)
         MOP_WORD: begin
            misalign_c   = (addr_lo != 2'b00);
            store_c.be   = 4'b1111;
            store_c.data = wdata;
            load_c       = rword;
         end
         MOP_HALF: begin
            misalign_c   = addr_lo[0];
            store_c.be   = addr_lo[1] ? 4'b1100 : 4'b0011;
            store_c.data = {2{wdata[15:0]}};
            load_c       = load_unsigned ? {16'h0000, half_sel}
                                         : {{16{half_sel[15]}}, half_sel};
         end
         MOP_BYTE: begin
            store_c.be   = 4'b0001 << addr_lo;
            store_c.data = {4{wdata[7:0]}};
            load_c       = load_unsigned ? {24'h000000, byte_sel}
                                         : {{24{byte_sel[7]}}, byte_sel};
         end
         default: misalign_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/dm_unit.sv
// Data-memory stage: byte-lane RAM, MMIO window (LED, cycle counter, fault status)
// and sticky illegal-access capture. Loads are combinational.
module dm_unit
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'h0000_7F00
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                mem_write,
   input  logic [1:0]          mem_op,
   input  logic                load_unsigned,
   output logic [DATA_W-1:0]   rdata,
   output logic [LED_W-1:0]    led,
   output logic                fault,
   output logic [DATA_W-1:0]   fault_addr
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   logic [DATA_W-1:0]     mem [DEPTH_WORDS];
   logic [DATA_W-1:0]     cycle_cnt;

   logic [IDX_W-1:0]      ram_idx_c;
   logic                  mmio_hit_c;
   logic                  in_ram_c;
   logic [DATA_W-1:0]     rword_c;
   store_t                store_c;
   logic [DATA_W-1:0]     load_c;
   logic                  misalign_c;
   logic                  illegal_c;
   logic [MMIO_OFF_W-1:0] off_c;
   logic                  mmio_wr_c;
   logic                  fault_set_c;
   logic                  status_clr_c;
   logic                  ram_wr_c;
   logic [DATA_W-1:0]     mmio_rd_c;

   assign mmio_hit_c = (addr[31:4] == MMIO_BASE[31:4]);
   assign in_ram_c   = !mmio_hit_c && ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
   assign ram_idx_c  = addr[IDX_W+1:2];
   assign rword_c    = in_ram_c ? mem[ram_idx_c] : '0;
   assign off_c      = addr[MMIO_OFF_W-1:0];

   dm_lane u_lane (
      .addr_lo       (addr[1:0]),
      .mem_op        (mem_op),
      .load_unsigned (load_unsigned),
      .wdata         (wdata),
      .rword         (rword_c),
      .store_c       (store_c),
      .load_c        (load_c),
      .misalign_c    (misalign_c)
   );

   // MMIO registers only answer full-word accesses.
   assign illegal_c    = misalign_c || (mmio_hit_c && (mem_op_e'(mem_op) != MOP_WORD));
   assign fault_set_c  = mem_write && illegal_c;
   assign mmio_wr_c    = mem_write && mmio_hit_c && !illegal_c;
   assign ram_wr_c     = mem_write && in_ram_c && !illegal_c;
   assign status_clr_c = mmio_wr_c && (off_c == OFF_STATUS) && wdata[STATUS_FAULT_BIT];

   always_comb begin
      mmio_rd_c = '0;
      case (off_c)
         OFF_LED:    mmio_rd_c = {16'h0000, led};
         OFF_CYCLE:  mmio_rd_c = cycle_cnt;
         OFF_STATUS: mmio_rd_c = 32'(fault) << STATUS_FAULT_BIT;
         OFF_FADDR:  mmio_rd_c = fault_addr;
         default:    mmio_rd_c = '0;
      endcase
   end

   always_comb begin
      rdata = '0;
      if (illegal_c)       rdata = '0;
      else if (mmio_hit_c) rdata = mmio_rd_c;
      else if (in_ram_c)   rdata = load_c;
   end

   // MMIO state; a fault in the same cycle as a clear takes precedence.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led        <= '0;
         cycle_cnt  <= '0;
         fault      <= 1'b0;
         fault_addr <= '0;
      end else begin
         if (mmio_wr_c && (off_c == OFF_LED))
            led <= wdata[LED_W-1:0];
         if (mmio_wr_c && (off_c == OFF_CYCLE))
            cycle_cnt <= '0;
         else
            cycle_cnt <= cycle_cnt + 32'd1;
         if (fault_set_c) begin
            fault <= 1'b1;
            if (!fault || status_clr_c)
               fault_addr <= addr;
         end else if (status_clr_c) begin
            fault      <= 1'b0;
            fault_addr <= '0;
         end
      end
   end

   // RAM array is not reset; only enabled lanes are written.
   always_ff @(posedge clk) begin
      if (ram_wr_c) begin
         for (int b = 0; b < int'(LANES); b++) begin
            if (store_c.be[b])
               mem[ram_idx_c][8*b +: 8] <= store_c.data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dm_unit.sv
// Self-checking bench for dm_unit: directed table, hand sequences and random traffic
// against a byte-addressed reference model.
module tb_dm_unit;

   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_7F00;
   localparam logic [1:0]  OW = 2'd0, OH = 2'd1, OB = 2'd2, OR = 2'd3;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_write;
   logic [1:0]  mem_op;
   logic        load_unsigned;
   logic [31:0] rdata;
   logic [15:0] led;
   logic        fault;
   logic [31:0] fault_addr;

   int checks;
   int errors;

   logic [31:0] m_mem [DEPTH];
   logic [15:0] m_led;
   logic [31:0] m_cnt;
   logic        m_fault;
   logic [31:0] m_faddr;

   typedef struct {
      logic [31:0] a;
      logic [31:0] w;
      logic        we;
      logic [1:0]  op;
      logic        lu;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];

   dm_unit #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
      .clk           (clk),
      .rst           (rst),
      .addr          (addr),
      .wdata         (wdata),
      .mem_write     (mem_write),
      .mem_op        (mem_op),
      .load_unsigned (load_unsigned),
      .rdata         (rdata),
      .led           (led),
      .fault         (fault),
      .fault_addr    (fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic bit in_mmio(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'd16);
   endfunction

   function automatic int size_of(input logic [1:0] op);
      return (op == OW) ? 4 : (op == OH) ? 2 : 1;
   endfunction

   function automatic bit m_illegal(input logic [31:0] a, input logic [1:0] op);
      if (op == OR) return 1'b1;
      if (a % size_of(op) != 0) return 1'b1;
      if (op != OW && in_mmio(a)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] op, input logic lu);
      logic [31:0] mask;
      logic [31:0] val;
      int          sz;
      if (m_illegal(a, op)) return 32'h0;
      if (in_mmio(a)) begin
         case (a - BASE)
            32'd0:   return {16'h0, m_led};
            32'd4:   return m_cnt;
            32'd8:   return {31'h0, m_fault};
            32'd12:  return m_faddr;
            default: return 32'h0;
         endcase
      end
      if ((a >> 2) >= DEPTH) return 32'h0;
      sz   = size_of(op);
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
      val  = (m_mem[a >> 2] >> (8 * (a % 4))) & mask;
      if (!lu && sz < 4 && val[8*sz-1]) val = val | ~mask;
      return val;
   endfunction

   task automatic m_edge(input logic [31:0] a, input logic [31:0] w, input logic we, input logic [1:0] op);
      logic [31:0] next_cnt;
      int          pos;
      next_cnt = m_cnt + 32'd1;
      if (we) begin
         if (m_illegal(a, op)) begin
            if (!m_fault) m_faddr = a;
            m_fault = 1'b1;
         end else if (in_mmio(a)) begin
            if (a - BASE == 32'd0) m_led = w[15:0];
            if (a - BASE == 32'd4) next_cnt = 32'h0;
            if (a - BASE == 32'd8 && w[0]) begin
               m_fault = 1'b0;
               m_faddr = 32'h0;
            end
         end else if ((a >> 2) < DEPTH) begin
            for (int k = 0; k < size_of(op); k++) begin
               pos = int'((a + 32'(k)) % 4);
               m_mem[a >> 2][8*pos +: 8] = w[8*k +: 8];
            end
         end
      end
      m_cnt = next_cnt;
   endtask

   // One bus cycle: drive, check combinational read, clock, check registered state.
   task automatic do_cycle(input logic [31:0] a, input logic [31:0] w, input logic we,
                           input logic [1:0] op, input logic lu, output logic [31:0] got);
      addr          = a;
      wdata         = w;
      mem_write     = we;
      mem_op        = op;
      load_unsigned = lu;
      #2;
      got = rdata;
      check("rdata", got, m_read(a, op, lu));
      @(posedge clk);
      m_edge(a, w, we, op);
      #1;
      check("led", {16'h0, led}, {16'h0, m_led});
      check("fault", {31'h0, fault}, {31'h0, m_fault});
      check("fault_addr", fault_addr, m_faddr);
   endtask

   logic [31:0] got;
   logic [31:0] ra;
   int          sel;

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 32'h0;
      m_led = 16'h0; m_cnt = 32'h0; m_fault = 1'b0; m_faddr = 32'h0;

      rst = 1'b0; addr = BASE + 32'd4; wdata = 32'h0; mem_write = 1'b0;
      mem_op = OW; load_unsigned = 1'b0;
      #1;
      check("rst_led", {16'h0, led}, 32'h0);
      check("rst_fault", {31'h0, fault}, 32'h0);
      check("rst_faddr", fault_addr, 32'h0);
      check("rst_cycle", rdata, 32'h0);
      #11 rst = 1'b1;

      for (int i = 0; i < 32; i++) do_cycle(32'(i * 4), 32'h0, 1'b1, OW, 1'b0, got);

      tbl.push_back('{32'h10, 32'h8899AABB, 1'b1, OW, 1'b0, 32'h0});
      tbl.push_back('{32'h10, 32'h0, 1'b0, OB, 1'b0, 32'hFFFFFFBB});
      tbl.push_back('{32'h11, 32'h0, 1'b0, OB, 1'b0, 32'hFFFFFFAA});
      tbl.push_back('{32'h12, 32'h0, 1'b0, OB, 1'b0, 32'hFFFFFF99});
      tbl.push_back('{32'h13, 32'h0, 1'b0, OB, 1'b0, 32'hFFFFFF88});
      tbl.push_back('{32'h10, 32'h0, 1'b0, OB, 1'b1, 32'h000000BB});
      tbl.push_back('{32'h11, 32'h0, 1'b0, OB, 1'b1, 32'h000000AA});
      tbl.push_back('{32'h12, 32'h0, 1'b0, OB, 1'b1, 32'h00000099});
      tbl.push_back('{32'h13, 32'h0, 1'b0, OB, 1'b1, 32'h00000088});
      tbl.push_back('{32'h12, 32'h0, 1'b0, OH, 1'b0, 32'hFFFF8899});
      tbl.push_back('{32'h20, 32'hFFFFFFFF, 1'b1, OW, 1'b0, 32'h0});
      tbl.push_back('{32'h22, 32'h00001234, 1'b1, OH, 1'b0, 32'hFFFFFFFF});
      tbl.push_back('{32'h20, 32'h0, 1'b0, OW, 1'b0, 32'h1234FFFF});
      tbl.push_back('{32'h21, 32'h0000005A, 1'b1, OB, 1'b0, 32'hFFFFFFFF});
      tbl.push_back('{32'h20, 32'h0, 1'b0, OW, 1'b1, 32'h12345AFF});
      tbl.push_back('{32'h20, 32'h0, 1'b0, OH, 1'b0, 32'h00005AFF});
      tbl.push_back('{32'h22, 32'h0, 1'b0, OH, 1'b1, 32'h00001234});
      tbl.push_back('{32'h10, 32'h0, 1'b0, OR, 1'b0, 32'h0});
      tbl.push_back('{32'h11, 32'h0, 1'b0, OH, 1'b0, 32'h0});
      tbl.push_back('{32'h12, 32'h0, 1'b0, OW, 1'b0, 32'h0});
      tbl.push_back('{32'h1000, 32'h55AA55AA, 1'b1, OW, 1'b0, 32'h0});
      tbl.push_back('{32'h1000, 32'h0, 1'b0, OW, 1'b0, 32'h0});
      foreach (tbl[i]) begin
         do_cycle(tbl[i].a, tbl[i].w, tbl[i].we, tbl[i].op, tbl[i].lu, got);
         check($sformatf("vec%0d", i), got, tbl[i].exp);
      end
      check("no_fault_after_table", {31'h0, fault}, 32'h0);

      // misaligned store is dropped and captured; later faults keep the first address
      do_cycle(32'h31, 32'hCAFEF00D, 1'b1, OW, 1'b0, got);
      check("fault_set", {31'h0, fault}, 32'h1);
      check("fault_addr_first", fault_addr, 32'h31);
      do_cycle(32'h30, 32'h0, 1'b0, OW, 1'b0, got);
      check("ram_unchanged", got, 32'h0);
      do_cycle(32'h42, 32'h1, 1'b1, OW, 1'b0, got);
      check("fault_addr_kept", fault_addr, 32'h31);
      do_cycle(BASE + 32'd12, 32'h0, 1'b0, OW, 1'b0, got);
      check("faddr_read", got, 32'h31);
      do_cycle(BASE + 32'd8, 32'h1, 1'b1, OW, 1'b0, got);
      check("status_read", got, 32'h1);
      check("fault_clr", {31'h0, fault}, 32'h0);
      check("faddr_clr", fault_addr, 32'h0);

      // cycle counter restart
      do_cycle(BASE + 32'd4, 32'h1234, 1'b1, OW, 1'b0, got);
      for (int i = 0; i < 5; i++) do_cycle(32'h0, 32'h0, 1'b0, OW, 1'b0, got);
      do_cycle(BASE + 32'd4, 32'h0, 1'b0, OW, 1'b0, got);
      check("cycle_5", got, 32'd5);

      // LED register and illegal sub-word MMIO store
      do_cycle(BASE, 32'hDEADBEEF, 1'b1, OW, 1'b0, got);
      check("led_val", {16'h0, led}, 32'h0000BEEF);
      do_cycle(BASE, 32'h0, 1'b0, OW, 1'b0, got);
      check("led_read", got, 32'h0000BEEF);
      do_cycle(BASE, 32'h11, 1'b1, OB, 1'b0, got);
      check("led_kept", {16'h0, led}, 32'h0000BEEF);
      check("mmio_byte_fault", {31'h0, fault}, 32'h1);
      do_cycle(BASE + 32'd8, 32'h1, 1'b1, OW, 1'b0, got);

      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 6)      ra = 32'h40 + 32'($urandom_range(0, 63));
         else if (sel < 8) ra = BASE + 32'($urandom_range(0, 15));
         else if (sel < 9) ra = 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
         else              ra = $urandom | 32'h0001_0000;
         do_cycle(ra, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), got);
      end

      // asynchronous reset between edges
      do_cycle(BASE, 32'h0000A5A5, 1'b1, OW, 1'b0, got);
      do_cycle(32'h33, 32'h0, 1'b1, OH, 1'b0, got);
      #2 rst = 1'b0;
      addr = BASE + 32'd4; mem_write = 1'b0; mem_op = OW;
      #1;
      check("arst_led", {16'h0, led}, 32'h0);
      check("arst_fault", {31'h0, fault}, 32'h0);
      check("arst_faddr", fault_addr, 32'h0);
      check("arst_cycle", rdata, 32'h0);
      m_led = 16'h0; m_cnt = 32'h0; m_fault = 1'b0; m_faddr = 32'h0;
      @(posedge clk);
      #2 rst = 1'b1;
      do_cycle(32'h10, 32'h0, 1'b0, OW, 1'b0, got);
      check("ram_survives_rst", got, 32'h8899AABB);
      do_cycle(BASE + 32'd4, 32'h0, 1'b0, OW, 1'b0, got);
      check("cycle_after_rst", got, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
